// File: rtl/meas_pld_arbiter_pkg.sv
// Shared definitions for the payload-FIFO write-port arbiter: FSM state
// encoding and the default filler word used when a burst is padded.
package meas_pld_arbiter_pkg;

  typedef enum logic [1:0] {
    MEAS_ARB_IDLE  = 2'd0,
    MEAS_ARB_BURST = 2'd1,
    MEAS_ARB_PAD   = 2'd2
  } meas_arb_state_e;

  // Wide enough for any practical WORD_WIDTH; users truncate it to their width.
  localparam logic [255:0] MEAS_ARB_PAD_WORD = '1;

endpackage

// File: rtl/meas_pld_arbiter_if.sv
// Producer request/data/ack bundle plus the payload-FIFO write port.
// The slave modport is the arbiter's view; master is the producer/FIFO side.
interface meas_pld_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int WORD_WIDTH = 64
);

  logic [NUM_SRC-1:0]            src_req;
  logic [NUM_SRC*WORD_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            src_ack;
  logic [WORD_WIDTH-1:0]         pld_fifo_din;
  logic                          pld_fifo_wr;
  logic                          pld_fifo_full;

  modport master (
    output src_req, src_data, pld_fifo_full,
    input  src_ack, pld_fifo_din, pld_fifo_wr
  );

  modport slave (
    input  src_req, src_data, pld_fifo_full,
    output src_ack, pld_fifo_din, pld_fifo_wr
  );

endinterface

// File: rtl/meas_pld_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// ptr, wrapping modulo NUM_SRC.
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  localparam int CW = IDX_W + 1;

  logic [CW-1:0] cand;

  // One spare bit keeps ptr+i from overflowing before the wrap subtraction.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= CW'(NUM_SRC)) begin
        cand = cand - CW'(NUM_SRC);
      end
      if (!valid && req[cand[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/meas_pld_arbiter.sv
// Round-robin arbiter for the payload-FIFO write port with atomic bursts and
// stall-timeout padding. Define MEAS_PLD_ARB_STATS_EN to build the stat counters.
module meas_pld_arbiter
  import meas_pld_arbiter_pkg::*;
#(
  parameter int                    NUM_SRC        = 4,
  parameter int                    WORD_WIDTH     = 64,
  parameter int                    WORDS_PER_MEAS = 2,
  parameter int                    GAP_TIMEOUT    = 16,
  parameter logic [WORD_WIDTH-1:0] PAD_WORD       = WORD_WIDTH'(MEAS_ARB_PAD_WORD)
) (
  input  logic                 clk,
  input  logic                 reset,
  meas_pld_arbiter_if.slave    bus,
  output logic                 err_abort,
  output logic [2:0]           abort_src,
  output logic [31:0]          stat_words,
  output logic [31:0]          stat_stall
);

  localparam int              IDX_W    = $clog2(NUM_SRC);
  localparam logic [3:0]      LAST_CNT = 4'(WORDS_PER_MEAS - 1);
  localparam logic [7:0]      GAP_LAST = 8'(GAP_TIMEOUT - 1);

  meas_arb_state_e       state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [3:0]            word_cnt_q, word_cnt_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic                  err_abort_q, err_abort_d;
  logic [2:0]            abort_src_q, abort_src_d;

  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic                  wr_raw;
  logic                  ack_en;
  logic                  use_pad;
  logic [IDX_W-1:0]      sel_idx;
  logic [WORD_WIDTH-1:0] sel_word;
  logic [WORD_WIDTH-1:0] din;
  logic [NUM_SRC-1:0]    ack_vec;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur);
    return (cur == IDX_W'(NUM_SRC - 1)) ? '0 : cur + 1'b1;
  endfunction

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (bus.src_req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= MEAS_ARB_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      err_abort_q <= 1'b0;
      abort_src_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      word_cnt_q  <= word_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      err_abort_q <= err_abort_d;
      abort_src_q <= abort_src_d;
    end
  end

  // A full FIFO with the owner still requesting is a stall, not a gap.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    word_cnt_d  = word_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    err_abort_d = 1'b0;
    abort_src_d = abort_src_q;
    case (state_q)
      MEAS_ARB_IDLE: begin
        if (wr_raw) begin
          owner_d    = pick_idx;
          word_cnt_d = 4'd1;
          gap_cnt_d  = '0;
          if (WORDS_PER_MEAS == 1) begin
            rr_ptr_d = next_idx(pick_idx);
          end else begin
            state_d = MEAS_ARB_BURST;
          end
        end
      end
      MEAS_ARB_BURST: begin
        if (bus.src_req[owner_q]) begin
          if (wr_raw) begin
            word_cnt_d = word_cnt_q + 4'd1;
            gap_cnt_d  = '0;
            if (word_cnt_q == LAST_CNT) begin
              state_d  = MEAS_ARB_IDLE;
              rr_ptr_d = next_idx(owner_q);
            end
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
          if (gap_cnt_q == GAP_LAST) begin
            state_d     = MEAS_ARB_PAD;
            err_abort_d = 1'b1;
            abort_src_d = 3'(owner_q);
          end
        end
      end
      MEAS_ARB_PAD: begin
        if (wr_raw) begin
          word_cnt_d = word_cnt_q + 4'd1;
          if (word_cnt_q == LAST_CNT) begin
            state_d  = MEAS_ARB_IDLE;
            rr_ptr_d = next_idx(owner_q);
          end
        end
      end
      default: state_d = MEAS_ARB_IDLE;
    endcase
  end

  always_comb begin
    wr_raw  = 1'b0;
    ack_en  = 1'b0;
    use_pad = 1'b0;
    sel_idx = owner_q;
    case (state_q)
      MEAS_ARB_IDLE: begin
        if (pick_valid && !bus.pld_fifo_full) begin
          wr_raw  = 1'b1;
          ack_en  = 1'b1;
          sel_idx = pick_idx;
        end
      end
      MEAS_ARB_BURST: begin
        if (bus.src_req[owner_q] && !bus.pld_fifo_full) begin
          wr_raw = 1'b1;
          ack_en = 1'b1;
        end
      end
      MEAS_ARB_PAD: begin
        if (!bus.pld_fifo_full) begin
          wr_raw  = 1'b1;
          use_pad = 1'b1;
        end
      end
      default: ;
    endcase
    sel_word = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_word = bus.src_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    din = use_pad ? PAD_WORD : sel_word;
    // Strobes are masked by reset so they drop the moment reset asserts.
    ack_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_vec[i] = ack_en && reset && (sel_idx == IDX_W'(i));
    end
  end

  assign bus.pld_fifo_wr  = wr_raw & reset;
  assign bus.pld_fifo_din = din;
  assign bus.src_ack      = ack_vec;
  assign err_abort        = err_abort_q;
  assign abort_src        = abort_src_q;

`ifdef MEAS_PLD_ARB_STATS_EN
  logic [31:0] stat_words_q, stat_words_d;
  logic [31:0] stat_stall_q, stat_stall_d;
  logic        stall;

  assign stall = (|bus.src_req) & bus.pld_fifo_full;

  always_comb begin
    stat_words_d = stat_words_q;
    stat_stall_d = stat_stall_q;
    if (wr_raw && (stat_words_q != '1)) begin
      stat_words_d = stat_words_q + 32'd1;
    end
    if (stall && (stat_stall_q != '1)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_stall = stat_stall_q;
`else
  assign stat_words = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_meas_pld_arbiter.sv
// Self-checking bench for meas_pld_arbiter: directed scenarios plus random
// traffic, compared every cycle against a burst-level reference model.
module tb_meas_pld_arbiter;

  localparam int             NS   = 4;
  localparam int             WW   = 64;
  localparam int             WPM  = 2;
  localparam int             GT   = 16;
  localparam logic [WW-1:0]  PADW = '1;

  typedef enum {MODE_FIXED, MODE_RANDOM} mode_e;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic        err_abort;
  logic [2:0]  abort_src;
  logic [31:0] stat_words;
  logic [31:0] stat_stall;

  always #5 clk = ~clk;

  meas_pld_arbiter_if #(.NUM_SRC(NS), .WORD_WIDTH(WW)) bus ();

  meas_pld_arbiter #(
    .NUM_SRC        (NS),
    .WORD_WIDTH     (WW),
    .WORDS_PER_MEAS (WPM),
    .GAP_TIMEOUT    (GT),
    .PAD_WORD       (PADW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .err_abort  (err_abort),
    .abort_src  (abort_src),
    .stat_words (stat_words),
    .stat_stall (stat_stall)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: burst owner (-1 when free), words done, idle run, pad flag.
  int      m_owner, m_done, m_idle, m_ptr, m_abort;
  bit      m_pad, m_err;
  longint  m_words, m_stall;
  int      n_owner, n_done, n_idle, n_ptr, n_abort;
  bit      n_pad, n_err;
  longint  n_words, n_stall;
  bit              e_wr;
  logic [NS-1:0]   e_ack;
  logic [WW-1:0]   e_din;

  int            seq[NS];
  int            sleep_cnt[NS];
  logic [NS-1:0] req_v = '0;
  logic [NS-1:0] last_ack = '0;
  bit            full_v = 1'b0;
  mode_e         mode = MODE_FIXED;
  logic [NS-1:0] fixed_mask = '0;
  bit            fixed_full = 1'b0;

  logic [WW-1:0] fifo_log[$];
  int            err_seen = 0;
  int            ack_seen = 0;

  function automatic logic [WW-1:0] wordOf(int src, int s);
    return {32'(src), 32'(s)};
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_owner = -1; m_done = 0; m_idle = 0; m_ptr = 0; m_abort = 0;
    m_pad = 1'b0; m_err = 1'b0; m_words = 0; m_stall = 0;
    last_ack = '0;
  endtask

  task automatic applyStimulus();
    if (mode == MODE_FIXED) begin
      req_v  = fixed_mask;
      full_v = fixed_full;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (req_v[i] && !last_ack[i]) begin
          if ($urandom_range(39) == 0) begin
            req_v[i]     = 1'b0;
            sleep_cnt[i] = $urandom_range(30);
          end
        end else if (sleep_cnt[i] > 0) begin
          sleep_cnt[i]--;
          req_v[i] = 1'b0;
        end else begin
          req_v[i] = ($urandom_range(2) != 0);
        end
      end
      full_v = ($urandom_range(4) == 0);
    end
    bus.src_req       = req_v;
    bus.pld_fifo_full = full_v;
    for (int i = 0; i < NS; i++) begin
      bus.src_data[i*WW +: WW] = wordOf(i, seq[i]);
    end
  endtask

  task automatic modelEval();
    int win;
    n_owner = m_owner; n_done = m_done; n_idle = m_idle; n_ptr = m_ptr;
    n_abort = m_abort; n_pad = m_pad; n_err = 1'b0;
    n_words = m_words; n_stall = m_stall;
    e_wr = 1'b0; e_ack = '0; e_din = '0;
    win = -1;
    if (reset) begin
      if (m_owner < 0) begin
        for (int k = 0; k < NS; k++) begin
          if (win < 0 && req_v[(m_ptr + k) % NS]) win = (m_ptr + k) % NS;
        end
        if (win >= 0 && !full_v) begin
          e_wr = 1'b1; e_ack[win] = 1'b1; e_din = wordOf(win, seq[win]);
          if (WPM == 1) n_ptr = (win + 1) % NS;
          else begin n_owner = win; n_done = 1; n_idle = 0; end
        end
      end else if (m_pad) begin
        if (!full_v) begin
          e_wr = 1'b1; e_din = PADW; n_done = m_done + 1;
          if (n_done == WPM) begin n_owner = -1; n_pad = 1'b0; n_ptr = (m_owner + 1) % NS; end
        end
      end else if (req_v[m_owner]) begin
        if (!full_v) begin
          e_wr = 1'b1; e_ack[m_owner] = 1'b1; e_din = wordOf(m_owner, seq[m_owner]);
          n_done = m_done + 1; n_idle = 0;
          if (n_done == WPM) begin n_owner = -1; n_ptr = (m_owner + 1) % NS; end
        end
      end else begin
        n_idle = m_idle + 1;
        if (n_idle == GT) begin n_pad = 1'b1; n_err = 1'b1; n_abort = m_owner; end
      end
      if (e_wr && m_words < 64'hFFFF_FFFF) n_words = m_words + 1;
      if ((|req_v) && full_v && m_stall < 64'hFFFF_FFFF) n_stall = m_stall + 1;
    end
  endtask

  task automatic modelCommit();
    if (!reset) begin
      modelReset();
    end else begin
      m_owner = n_owner; m_done = n_done; m_idle = n_idle; m_ptr = n_ptr;
      m_abort = n_abort; m_pad = n_pad; m_err = n_err;
      m_words = n_words; m_stall = n_stall;
      for (int i = 0; i < NS; i++) if (e_ack[i]) seq[i]++;
      last_ack = e_ack;
    end
  endtask

  task automatic compareAll();
    checkOutput("wr", 64'(bus.pld_fifo_wr), 64'(e_wr));
    checkOutput("ack", 64'(bus.src_ack), 64'(e_ack));
    if (e_wr) checkOutput("din", bus.pld_fifo_din, e_din);
    checkOutput("err_abort", 64'(err_abort), 64'(m_err));
    checkOutput("abort_src", 64'(abort_src), 64'(m_abort));
`ifdef MEAS_PLD_ARB_STATS_EN
    checkOutput("stat_words", 64'(stat_words), 64'(m_words));
    checkOutput("stat_stall", 64'(stat_stall), 64'(m_stall));
`else
    checkOutput("stat_words", 64'(stat_words), 64'd0);
    checkOutput("stat_stall", 64'(stat_stall), 64'd0);
`endif
    if (bus.pld_fifo_wr) fifo_log.push_back(bus.pld_fifo_din);
    if (err_abort) err_seen++;
    if (|bus.src_ack) ack_seen++;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    applyStimulus();
    #1;
    modelEval();
    compareAll();
    @(posedge clk);
    modelCommit();
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    modelReset();
    repeat (3) stepCycle();
    #2;
    reset = 1'b1;
  endtask

  function automatic int idOf(int k);
    logic [WW-1:0] w;
    w = fifo_log[k];
    return int'(w[63:32]);
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt[NS];
    int exp_ids[6];
    int base, err_base, ack_base, pads, cyc;
    exp_ids = '{0, 0, 2, 2, 0, 0};
    for (int i = 0; i < NS; i++) begin seq[i] = 0; sleep_cnt[i] = 0; end
    bus.src_req = '0; bus.src_data = '0; bus.pld_fifo_full = 1'b0;

    // Reset with all producers requesting: nothing may be written or acked.
    fixed_mask = '1;
    doReset();
    checkOutput("rst_abort_src", 64'(abort_src), 64'd0);

    $display("[TB] basic burst: src0 and src2");
    doReset();
    fixed_mask = 4'b0101;
    fifo_log.delete();
    repeat (6) stepCycle();
    checkOutput("basic_count", 64'(fifo_log.size()), 64'd6);
    for (int k = 0; k < 6; k++) checkOutput("basic_order", 64'(idOf(k)), 64'(exp_ids[k]));

    $display("[TB] fairness: all four requesting");
    doReset();
    fixed_mask = 4'b1111;
    fifo_log.delete();
    repeat (400) stepCycle();
    for (int i = 0; i < NS; i++) cnt[i] = 0;
    for (int k = 0; k < fifo_log.size(); k++) if (idOf(k) < NS) cnt[idOf(k)]++;
    for (int i = 0; i < NS; i++) checkOutput("fair_share", 64'(cnt[i]), 64'd100);
    for (int b = 0; b < 5; b++) checkOutput("fair_order", 64'(idOf(2 * b)), 64'(b % NS));

    $display("[TB] backpressure mid-burst");
    stepCycle();
    fixed_full = 1'b1;
    base = fifo_log.size(); err_base = err_seen; ack_base = ack_seen;
    repeat (5) stepCycle();
    checkOutput("bp_no_write", 64'(fifo_log.size() - base), 64'd0);
    checkOutput("bp_no_ack", 64'(ack_seen - ack_base), 64'd0);
    fixed_full = 1'b0;
    repeat (2) stepCycle();
    checkOutput("bp_finish_src", 64'(idOf(fifo_log.size() - 2)), 64'd0);
    checkOutput("bp_next_src", 64'(idOf(fifo_log.size() - 1)), 64'd1);
    checkOutput("bp_no_abort", 64'(err_seen - err_base), 64'd0);

    $display("[TB] abort: src1 stalls after first word");
    doReset();
    fixed_mask = 4'b0010;
    stepCycle();
    fixed_mask = 4'b0100;
    fifo_log.delete();
    err_base = err_seen;
    repeat (22) stepCycle();
    checkOutput("abort_pulses", 64'(err_seen - err_base), 64'd1);
    checkOutput("abort_src_val", 64'(abort_src), 64'd1);
    pads = 0;
    for (int k = 0; k < fifo_log.size(); k++) if (fifo_log[k] == PADW) pads++;
    checkOutput("abort_pad_words", 64'(pads), 64'd1);
    checkOutput("abort_first_pad", fifo_log[0], PADW);
    checkOutput("abort_next_grant", 64'(idOf(1)), 64'd2);

    $display("[TB] asynchronous reset mid-burst");
    @(negedge clk);
    applyStimulus();
    #1;
    modelEval();
    checkOutput("pre_rst_wr", 64'(bus.pld_fifo_wr), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_wr", 64'(bus.pld_fifo_wr), 64'd0);
    checkOutput("async_rst_ack", 64'(bus.src_ack), 64'd0);
    @(posedge clk);
    modelCommit();
    repeat (2) stepCycle();
    #2;
    reset = 1'b1;
    fixed_mask = 4'b1111;
    fifo_log.delete();
    stepCycle();
    checkOutput("post_rst_winner", 64'(idOf(0)), 64'd0);

    $display("[TB] statistics: 100 words, 7 stall cycles");
    doReset();
    fixed_mask = 4'b1111;
    fifo_log.delete();
    cyc = 0;
    while (fifo_log.size() < 100 && cyc < 200) begin
      fixed_full = (cyc inside {10, 11, 12, 40, 41, 70, 90});
      stepCycle();
      cyc++;
    end
    fixed_full = 1'b0;
    #1;
    checkOutput("stats_word_count", 64'(fifo_log.size()), 64'd100);
`ifdef MEAS_PLD_ARB_STATS_EN
    checkOutput("stats_words", 64'(stat_words), 64'd100);
    checkOutput("stats_stall", 64'(stat_stall), 64'd7);
`else
    checkOutput("stats_words", 64'(stat_words), 64'd0);
    checkOutput("stats_stall", 64'(stat_stall), 64'd0);
`endif

    $display("[TB] randomized traffic");
    doReset();
    mode = MODE_RANDOM;
    req_v = '0;
    repeat (3000) stepCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/meas_pld_arbiter.md
# meas_pld_arbiter

Round-robin arbiter sharing the single payload-FIFO write port of the event-packet datapath (`pld_fifo_din`/`pld_fifo_wr`/`pld_fifo_full`) among several measurement producers. Each measurement is a fixed burst of words. A burst is written atomically, so consecutive FIFO words always belong to one measurement and event-packet payloads stay measurement-aligned. A stalled producer cannot wedge the port: after a timeout the arbiter pads the burst and releases the grant.

## Interface
- `NUM_SRC`, 4: number of producers, 2..8.
- `WORD_WIDTH`, 64: payload word width.
- `WORDS_PER_MEAS`, 2: words per measurement burst, 1..8.
- `GAP_TIMEOUT`, 16: idle cycles tolerated mid-burst before padding, 1..255.
- `PAD_WORD`, all-ones: filler word written on abort.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `src_req` in NUM_SRC: producer i has a word valid.
- `src_data` in NUM_SRC*WORD_WIDTH: producer i word at slice [i*WORD_WIDTH +: WORD_WIDTH].
- `src_ack` out NUM_SRC: one-hot; word of producer i consumed this cycle.
- `pld_fifo_din` out WORD_WIDTH: word to payload FIFO.
- `pld_fifo_wr` out 1: write strobe.
- `pld_fifo_full` in 1: FIFO full; no write while high.
- `err_abort` out 1: one-cycle pulse when a burst is padded.
- `abort_src` out 3: producer index of last abort, held.
- `stat_words` out 32: words written, saturating (statistics build only).
- `stat_stall` out 32: cycles with pending request and full FIFO, saturating (statistics build only).

## Operation
- States: IDLE, BURST, PAD. Registers: `owner`, `rr_ptr`, `word_cnt`, `gap_cnt`.
- IDLE, any `src_req` and `!pld_fifo_full`:
  - Winner is the first requester at or after `rr_ptr`, modulo NUM_SRC.
  - Write its word and ack it; `owner`=winner; `word_cnt`=1.
  - If WORDS_PER_MEAS==1, stay in IDLE and set `rr_ptr`=winner+1. Otherwise go to BURST.
- BURST, `src_req[owner]` and `!full`:
  - Write `src_data[owner]` and ack owner; `word_cnt`++; `gap_cnt`=0.
  - On the last word: go to IDLE, `rr_ptr`=owner+1 mod NUM_SRC.
- BURST, `!src_req[owner]`:
  - `gap_cnt`++.
  - When `gap_cnt` reaches GAP_TIMEOUT: go to PAD, pulse `err_abort`, `abort_src`=owner.
- BURST, `src_req[owner]` and full: stall; `gap_cnt` is held and does not count.
- PAD: write PAD_WORD on each `!full` cycle, no ack, until `word_cnt`==WORDS_PER_MEAS. Then go to IDLE, `rr_ptr`=owner+1.
- Other producers' `src_req` are ignored while owner is in BURST or PAD.
- A producer whose request arrives late during PAD is not acked; its next word starts a new burst only after winning arbitration.
- Reset values: state IDLE, `rr_ptr`=0, counters 0, `abort_src`=0.
- During reset: `pld_fifo_wr`=0, `src_ack`=0, `err_abort`=0, stats=0.
- Reset mid-burst abandons the burst. The FIFO is reset by the same reset.

## Timing
- `pld_fifo_wr`, `pld_fifo_din` and `src_ack` are combinational from state, `src_req` and `pld_fifo_full`. Zero-latency valid/ready: a word transfers in the cycle where both req and !full are high.
- The producer must hold `src_data` stable while `src_req` is high and unacked. It advances to the next word the cycle after an ack.
- A full burst with no stalls takes WORDS_PER_MEAS consecutive cycles. The next burst can start the following cycle (IDLE is evaluated combinationally in the cycle after the last word).
- `err_abort` is registered; it rises in the cycle the state enters PAD.
- `pld_fifo_full` high blocks every write in that cycle, in all states.

## Configuration
- `MEAS_PLD_ARB_STATS_EN` defined: `stat_words` and `stat_stall` counters are built. Both are 32-bit, saturating, and cleared by reset.
- Macro undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- Shared package/include: the state encoding (`MEAS_ARB_IDLE`, `MEAS_ARB_BURST`, `MEAS_ARB_PAD`) and the default PAD_WORD constant.
- One sub-module, `rr_pick`: combinational round-robin priority picker with inputs `req[NUM_SRC]` and `ptr`, outputs `valid` and `idx`.

## Test plan
- Basic burst: src0 and src2 request continuously, FIFO never full, WORDS_PER_MEAS=2 -> FIFO sequence src0,src0,src2,src2,src0,src0..., with no idle cycle between bursts.
- Fairness: all 4 request continuously -> bursts granted in order 0,1,2,3,0; each source gets 25% of words over 400 cycles.
- Backpressure: `pld_fifo_full` high for 5 cycles mid-burst -> no write or ack during those cycles, no abort, burst completes after full drops.
- Abort: src1 drops req after word 0, GAP_TIMEOUT=16 -> `err_abort` pulses once, `abort_src`=1, one PAD_WORD written, next grant goes to src2.
- Async reset: `reset` asserted mid-burst between clock edges -> `pld_fifo_wr` and `src_ack` go to 0 immediately; after release `rr_ptr`=0 and src0 wins first.
- Statistics build: 100 words written with 7 stall cycles -> `stat_words`=100, `stat_stall`=7. Non-statistics build: both ports read 0.
